apb_csr_irq_bank: RTL and testbench
===================================

Name: apb_csr_irq_bank

Overview:
Parametrised APB slave control/status register bank with NUM_IRQ interrupt channels. It replaces the fixed single-interrupt CSR block and adds:
- per-channel level/edge mode, mask, and sticky write-1-to-clear status
- software interrupt set and a saturating event counter
- byte strobes, programmable wait states and error response
It sits between the APB interconnect and peripheral interrupt sources and drives one combined interrupt line.

Parameters:
DATA_WIDTH, 32, APB data width; multiple of 8, 8..32.
ADDR_WIDTH, 8, APB byte-address width.
NUM_IRQ, 8, interrupt channels, 1..DATA_WIDTH.
WAIT_STATES, 0, extra access-phase cycles before pready, 0..3.
ID_VALUE, 'hAF, ID register constant.
SCRATCH_RESET, 'hAF, SCRATCH reset value.

Ports:
clk  in  1  clock, all state on rising edge.
rst  in  1  asynchronous, active-high reset.
psel  in  1  APB select.
penable  in  1  APB enable (access phase).
pwrite  in  1  1=write, 0=read.
paddr  in  ADDR_WIDTH  byte address.
pwdata  in  DATA_WIDTH  write data.
pstrb  in  DATA_WIDTH/8  write byte strobes.
prdata  out  DATA_WIDTH  read data, registered.
pready  out  1  transfer complete.
pslverr  out  1  error response, valid only with pready.
irq_in  in  NUM_IRQ  interrupt sources, synchronous to clk.
irq  out  1  registered OR of (status & mask).

Behaviour:
- Register index = paddr >> log2(DATA_WIDTH/8); low byte-offset bits are ignored.
  0 ID (RO), 1 SCRATCH (RW), 2 IRQ_MODE (RW), 3 IRQ_MASK (RW), 4 IRQ_STATUS (RO/W1C), 5 IRQ_SET (WO, reads 0), 6 IRQ_RAW (RO), 7 EVT_CNT (RO, write clears).
- Bits above NUM_IRQ in the IRQ registers read 0 and ignore writes.
- Reset values: prdata=0, pready=0, pslverr=0, irq=0, SCRATCH=SCRATCH_RESET, MODE/MASK/STATUS=0, EVT_CNT=0, irq_in_q=0, FSM=IDLE.
- Transfer FSM:
  - IDLE -> ACCESS on psel & !penable.
  - In ACCESS a wait counter counts from 0; pready=1 when counter==WAIT_STATES & psel & penable.
  - Completion (pready=1) -> IDLE, or directly ACCESS if another setup follows.
  - psel dropping in ACCESS aborts the transfer -> IDLE with no state change.
- Reads: prdata is loaded at the setup-cycle edge (index decoded then) and held until the next read setup. Readback reflects register state before any same-cycle update.
- Writes commit at the edge where psel & penable & pready & pwrite.
  - SCRATCH, MODE and MASK update only the bytes whose pstrb bit is 1.
  - W1C/SET/EVT_CNT actions use pwdata with all strobes treated as active.
- pslverr=1 with pready for: unmapped index (>7), write to ID or IRQ_RAW, read of IRQ_SET. An error transfer changes no state; its read data is 0.
- Per-channel set condition: level mode (MODE=0) irq_in=1; edge mode (MODE=1) irq_in & !irq_in_q, where irq_in_q is irq_in delayed one cycle. A write to IRQ_SET with bit=1 also sets.
- STATUS is set regardless of mask. A W1C write clears bits written 1.
- Set and clear on the same channel in the same cycle: set wins, bit stays 1.
- irq = registered |(STATUS & MASK), so irq follows a status or mask change by one cycle.
- EVT_CNT increments by 1 in any cycle where at least one STATUS bit goes 0->1, and saturates at all-ones. A write clears it; if an event occurs in the same cycle the result is 1.
- Reset asserted mid-transfer forces all of the above reset values immediately. pready stays 0 until a new setup phase.

Test Plan:
- After reset, read idx0/idx1 (WAIT_STATES=0) -> prdata 'hAF, 'hAF, pslverr=0; pready high in the first access cycle.
- WAIT_STATES=2: write SCRATCH 'h12345678 with pstrb=4'b0101 -> pready asserted in the 3rd access cycle; readback 'h00340078.
- MODE=0, MASK=1, irq_in[0] pulsed 1 cycle -> STATUS=1, irq=1 one cycle after STATUS; W1C 1 -> STATUS=0, irq=0. With irq_in[0] held high, the W1C leaves STATUS=1.
- MODE[3]=1, irq_in[3] held high 10 cycles -> STATUS[3] set once, EVT_CNT=1. MASK[3]=0 -> irq=0. Write MASK[3]=1 -> irq=1.
- IRQ_SET write 'h81 -> STATUS='h81, EVT_CNT incremented by 1 (not 2). Read IRQ_SET -> pslverr=1, prdata=0.
- Write to idx 9 or ID -> pslverr=1, no register change. Assert rst during an access phase -> pready=0 and all registers at reset values.

Source files
------------

// File: rtl/apb_csr_irq_bank.sv
// APB slave CSR bank with NUM_IRQ interrupt channels: per-channel level/edge mode,
// mask, sticky W1C status, software set, saturating event counter and wait states.
module apb_csr_irq_bank #(
    parameter int                    DATA_WIDTH    = 32,
    parameter int                    ADDR_WIDTH    = 8,
    parameter int                    NUM_IRQ       = 8,
    parameter int                    WAIT_STATES   = 0,
    parameter logic [DATA_WIDTH-1:0] ID_VALUE      = 'hAF,
    parameter logic [DATA_WIDTH-1:0] SCRATCH_RESET = 'hAF
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    psel,
    input  logic                    penable,
    input  logic                    pwrite,
    input  logic [ADDR_WIDTH-1:0]   paddr,
    input  logic [DATA_WIDTH-1:0]   pwdata,
    input  logic [DATA_WIDTH/8-1:0] pstrb,
    output logic [DATA_WIDTH-1:0]   prdata,
    output logic                    pready,
    output logic                    pslverr,
    input  logic [NUM_IRQ-1:0]      irq_in,
    output logic                    irq
);

    localparam int         NUM_BYTES = DATA_WIDTH / 8;
    localparam int         OFF_BITS  = (NUM_BYTES > 1) ? $clog2(NUM_BYTES) : 0;
    localparam logic [1:0] WAIT_LAST = 2'(WAIT_STATES);

    typedef enum logic {S_IDLE, S_ACCESS} state_t;
    typedef enum logic [2:0] {
        R_ID, R_SCRATCH, R_MODE, R_MASK, R_STATUS, R_SET, R_RAW, R_EVT
    } reg_idx_t;

    state_t                  state;
    logic [1:0]              wait_cnt;
    logic [DATA_WIDTH-1:0]   scratch;
    logic [NUM_IRQ-1:0]      mode;
    logic [NUM_IRQ-1:0]      mask;
    logic [NUM_IRQ-1:0]      status;
    logic [NUM_IRQ-1:0]      irq_in_q;
    logic [DATA_WIDTH-1:0]   evt_cnt;

    logic [ADDR_WIDTH-1:0]   idx;
    reg_idx_t                reg_sel;
    logic                    unmapped;
    logic                    access_err;
    logic                    setup;
    logic                    wr_commit;
    logic [DATA_WIDTH-1:0]   rd_val;
    logic [DATA_WIDTH-1:0]   byte_mask;
    logic [NUM_IRQ-1:0]      set_vec;
    logic [NUM_IRQ-1:0]      clr_vec;
    logic [NUM_IRQ-1:0]      status_nxt;
    logic                    new_evt;

    assign idx      = paddr >> OFF_BITS;
    assign reg_sel  = reg_idx_t'(idx[2:0]);
    assign unmapped = (idx > ADDR_WIDTH'(7));
    assign setup    = psel & ~penable;

    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        access_err = 1'b0;
        if (unmapped)
            access_err = 1'b1;
        else if (pwrite && (reg_sel == R_ID || reg_sel == R_RAW))
            access_err = 1'b1;
        else if (!pwrite && reg_sel == R_SET)
            access_err = 1'b1;
    end

    assign pready    = (state == S_ACCESS) & psel & penable & (wait_cnt == WAIT_LAST);
    assign pslverr   = pready & access_err;
    assign wr_commit = pready & pwrite & ~access_err;

    always_comb begin
        rd_val = '0;
        case (reg_sel)
            R_ID:      rd_val = ID_VALUE;
            R_SCRATCH: rd_val = scratch;
            R_MODE:    rd_val = DATA_WIDTH'(mode);
            R_MASK:    rd_val = DATA_WIDTH'(mask);
            R_STATUS:  rd_val = DATA_WIDTH'(status);
            R_RAW:     rd_val = DATA_WIDTH'(irq_in);
            R_EVT:     rd_val = evt_cnt;
            default:   rd_val = '0;
        endcase
    end

    always_comb begin
        byte_mask = '0;
        for (int b = 0; b < NUM_BYTES; b++)
            byte_mask[b*8 +: 8] = {8{pstrb[b]}};
    end

    // Software set and hardware set are merged so a same-cycle W1C never wins over a set.
    assign set_vec    = (irq_in & ~mode) | (irq_in & ~irq_in_q & mode)
                      | ((wr_commit && reg_sel == R_SET) ? pwdata[NUM_IRQ-1:0] : '0);
    assign clr_vec    = (wr_commit && reg_sel == R_STATUS) ? pwdata[NUM_IRQ-1:0] : '0;
    assign status_nxt = (status & ~clr_vec) | set_vec;
    assign new_evt    = |(set_vec & ~status);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= S_IDLE;
            wait_cnt <= '0;
            prdata   <= '0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
            if (setup) begin
                state    <= S_ACCESS;
                wait_cnt <= '0;
                if (!pwrite)
                    prdata <= access_err ? '0 : rd_val;
            end else if (state == S_ACCESS) begin
                if (!psel || pready)
                    state <= S_IDLE;
                else if (penable)
                    wait_cnt <= wait_cnt + 2'd1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            scratch  <= SCRATCH_RESET;
            mode     <= '0;
            mask     <= '0;
            status   <= '0;
            irq_in_q <= '0;
            evt_cnt  <= '0;
            irq      <= 1'b0;
        end else begin
            irq_in_q <= irq_in;
            status   <= status_nxt;
            irq      <= |(status & mask);
            if (wr_commit && reg_sel == R_SCRATCH)
                scratch <= (scratch & ~byte_mask) | (pwdata & byte_mask);
            if (wr_commit && reg_sel == R_MODE)
                mode <= (mode & ~byte_mask[NUM_IRQ-1:0]) | (pwdata[NUM_IRQ-1:0] & byte_mask[NUM_IRQ-1:0]);
            if (wr_commit && reg_sel == R_MASK)
                mask <= (mask & ~byte_mask[NUM_IRQ-1:0]) | (pwdata[NUM_IRQ-1:0] & byte_mask[NUM_IRQ-1:0]);
            if (wr_commit && reg_sel == R_EVT)
                evt_cnt <= new_evt ? DATA_WIDTH'(1) : '0;
            else if (new_evt && evt_cnt != '1)
                evt_cnt <= evt_cnt + DATA_WIDTH'(1);
        end
    end

endmodule

// File: tb/tb_apb_csr_irq_bank.sv
// Directed bench for apb_csr_irq_bank: one instance with no wait states, one with two.
module tb_apb_csr_irq_bank;

    logic        clk = 1'b0;
    logic        rst;
    logic        psel0, psel2, penable, pwrite;
    logic [7:0]  paddr;
    logic [31:0] pwdata;
    logic [3:0]  pstrb;
    logic [7:0]  irq_in;
    logic [31:0] prdata0, prdata2;
    logic        pready0, pready2, pslverr0, pslverr2, irq0, irq2;

    int errors = 0;
    int checks = 0;

    localparam logic [7:0] A_ID = 8'h00, A_SCR = 8'h04, A_MODE = 8'h08, A_MASK = 8'h0C;
    localparam logic [7:0] A_STAT = 8'h10, A_SET = 8'h14, A_RAW = 8'h18, A_EVT = 8'h1C;
    localparam logic [7:0] A_BAD = 8'h24;

    always #5 clk = ~clk;

    apb_csr_irq_bank #(.WAIT_STATES(0)) u_ws0 (
        .clk(clk), .rst(rst), .psel(psel0), .penable(penable), .pwrite(pwrite),
        .paddr(paddr), .pwdata(pwdata), .pstrb(pstrb), .prdata(prdata0),
        .pready(pready0), .pslverr(pslverr0), .irq_in(irq_in), .irq(irq0)
    );

    apb_csr_irq_bank #(.WAIT_STATES(2)) u_ws2 (
        .clk(clk), .rst(rst), .psel(psel2), .penable(penable), .pwrite(pwrite),
        .paddr(paddr), .pwdata(pwdata), .pstrb(pstrb), .prdata(prdata2),
        .pready(pready2), .pslverr(pslverr2), .irq_in(irq_in), .irq(irq2)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One APB transfer; returns read data, error flag and number of access cycles.
    task automatic apb(input bit tgt, input bit wr, input logic [7:0] addr,
                       input logic [31:0] wdata, input logic [3:0] strb,
                       output logic [31:0] rdata, output logic err, output int cycles);
        @(negedge clk);
        if (tgt) psel2 = 1'b1; else psel0 = 1'b1;
        penable = 1'b0; pwrite = wr; paddr = addr; pwdata = wdata; pstrb = strb;
        @(negedge clk);
        penable = 1'b1;
        cycles  = 1;
        #1;
        while (!(tgt ? pready2 : pready0) && cycles < 16) begin
            @(negedge clk);
            cycles++;
            #1;
        end
        check("pready_seen", {31'd0, (tgt ? pready2 : pready0)}, 32'd1);
        err   = tgt ? pslverr2 : pslverr0;
        rdata = tgt ? prdata2 : prdata0;
        @(negedge clk);
        psel0 = 1'b0; psel2 = 1'b0; penable = 1'b0; pwrite = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [31:0] rd;
        logic        er;
        int          cyc;

        rst = 1'b1; psel0 = 0; psel2 = 0; penable = 0; pwrite = 0;
        paddr = 0; pwdata = 0; pstrb = 0; irq_in = 0;
        repeat (3) @(negedge clk);
        check("rst_pready",  {31'd0, pready0},  32'd0);
        check("rst_pslverr", {31'd0, pslverr0}, 32'd0);
        check("rst_prdata",  prdata0,           32'd0);
        check("rst_irq",     {31'd0, irq0},     32'd0);
        rst = 1'b0;

        // Reads after reset, no wait states
        apb(0, 0, A_ID, 0, 0, rd, er, cyc);
        check("id_data", rd, 32'hAF);
        check("id_err",  {31'd0, er}, 32'd0);
        check("id_cycles", cyc, 1);
        apb(0, 0, A_SCR, 0, 0, rd, er, cyc);
        check("scr_data", rd, 32'hAF);
        check("scr_err",  {31'd0, er}, 32'd0);

        // Two wait states with byte strobes
        apb(1, 1, A_SCR, 32'h12345678, 4'b0101, rd, er, cyc);
        check("ws2_wr_cycles", cyc, 3);
        check("ws2_wr_err", {31'd0, er}, 32'd0);
        apb(1, 0, A_SCR, 0, 0, rd, er, cyc);
        check("ws2_rd_cycles", cyc, 3);
        check("ws2_strb_data", rd, 32'h00340078);

        // Level channel 0, single-cycle pulse
        apb(0, 1, A_MASK, 32'h1, 4'hF, rd, er, cyc);
        @(negedge clk); irq_in[0] = 1'b1;
        @(negedge clk); irq_in[0] = 1'b0;
        #1 check("irq_lag", {31'd0, irq0}, 32'd0);
        @(negedge clk);
        #1 check("irq_after_status", {31'd0, irq0}, 32'd1);
        apb(0, 0, A_STAT, 0, 0, rd, er, cyc);
        check("status_pulse", rd, 32'h1);
        apb(0, 0, A_EVT, 0, 0, rd, er, cyc);
        check("evt_pulse", rd, 32'd1);
        apb(0, 1, A_STAT, 32'h1, 4'hF, rd, er, cyc);
        apb(0, 0, A_STAT, 0, 0, rd, er, cyc);
        check("status_w1c", rd, 32'h0);
        check("irq_w1c", {31'd0, irq0}, 32'd0);

        // Level source held high: W1C cannot clear it
        irq_in[0] = 1'b1;
        apb(0, 1, A_STAT, 32'h1, 4'hF, rd, er, cyc);
        apb(0, 0, A_STAT, 0, 0, rd, er, cyc);
        check("status_set_wins", rd, 32'h1);
        apb(0, 0, A_EVT, 0, 0, rd, er, cyc);
        check("evt_held", rd, 32'd2);
        irq_in[0] = 1'b0;
        apb(0, 1, A_STAT, 32'h1, 4'hF, rd, er, cyc);
        apb(0, 1, A_EVT, 32'h0, 4'hF, rd, er, cyc);
        apb(0, 0, A_EVT, 0, 0, rd, er, cyc);
        check("evt_clear", rd, 32'd0);

        // Edge channel 3, masked off, then unmasked
        apb(0, 1, A_MODE, 32'h08, 4'hF, rd, er, cyc);
        @(negedge clk); irq_in[3] = 1'b1;
        repeat (10) @(negedge clk);
        irq_in[3] = 1'b0;
        apb(0, 0, A_STAT, 0, 0, rd, er, cyc);
        check("edge_status", rd, 32'h08);
        apb(0, 0, A_EVT, 0, 0, rd, er, cyc);
        check("edge_evt_once", rd, 32'd1);
        check("edge_masked_irq", {31'd0, irq0}, 32'd0);
        apb(0, 1, A_MASK, 32'h09, 4'hF, rd, er, cyc);
        #1 check("unmask_irq_lag", {31'd0, irq0}, 32'd0);
        @(negedge clk);
        #1 check("unmask_irq", {31'd0, irq0}, 32'd1);
        apb(0, 1, A_STAT, 32'h08, 4'hF, rd, er, cyc);

        // Software set of two channels counts as one event
        apb(0, 1, A_EVT, 32'h0, 4'hF, rd, er, cyc);
        apb(0, 1, A_SET, 32'h81, 4'hF, rd, er, cyc);
        apb(0, 0, A_STAT, 0, 0, rd, er, cyc);
        check("set_status", rd, 32'h81);
        apb(0, 0, A_EVT, 0, 0, rd, er, cyc);
        check("set_evt", rd, 32'd1);
        apb(0, 0, A_SET, 0, 0, rd, er, cyc);
        check("set_rd_err", {31'd0, er}, 32'd1);
        check("set_rd_data", rd, 32'd0);
        apb(0, 1, A_STAT, 32'hFF, 4'hF, rd, er, cyc);

        // Error responses leave state untouched
        apb(0, 1, A_BAD, 32'hDEAD, 4'hF, rd, er, cyc);
        check("bad_wr_err", {31'd0, er}, 32'd1);
        apb(0, 0, A_SCR, 0, 0, rd, er, cyc);
        check("bad_wr_nochange", rd, 32'hAF);
        apb(0, 1, A_ID, 32'h55, 4'hF, rd, er, cyc);
        check("id_wr_err", {31'd0, er}, 32'd1);
        apb(0, 0, A_ID, 0, 0, rd, er, cyc);
        check("id_unchanged", rd, 32'hAF);
        apb(0, 1, A_RAW, 32'h1, 4'hF, rd, er, cyc);
        check("raw_wr_err", {31'd0, er}, 32'd1);
        apb(0, 0, A_BAD, 0, 0, rd, er, cyc);
        check("bad_rd_err", {31'd0, er}, 32'd1);
        check("bad_rd_data", rd, 32'd0);

        // Aborted write on the wait-state instance
        @(negedge clk);
        psel2 = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = A_SCR; pwdata = 32'h11111111; pstrb = 4'hF;
        @(negedge clk); penable = 1'b1;
        #1 check("abort_no_ready", {31'd0, pready2}, 32'd0);
        @(negedge clk); psel2 = 1'b0; penable = 1'b0; pwrite = 1'b0;
        apb(1, 0, A_SCR, 0, 0, rd, er, cyc);
        check("abort_nochange", rd, 32'h00340078);

        // Reset in the middle of an access phase
        apb(0, 1, A_SET, 32'h01, 4'hF, rd, er, cyc);
        @(negedge clk);
        #1 check("pre_rst_irq", {31'd0, irq0}, 32'd1);
        @(negedge clk);
        psel0 = 1'b1; penable = 1'b0; pwrite = 1'b0; paddr = A_MASK;
        @(negedge clk); penable = 1'b1;
        #1 check("pre_rst_ready", {31'd0, pready0}, 32'd1);
        check("pre_rst_data", prdata0, 32'h09);
        rst = 1'b1;
        #1 check("mid_rst_ready", {31'd0, pready0}, 32'd0);
        check("mid_rst_data", prdata0, 32'd0);
        check("mid_rst_irq", {31'd0, irq0}, 32'd0);
        @(negedge clk);
        psel0 = 1'b0; penable = 1'b0;
        @(negedge clk); rst = 1'b0;
        apb(0, 0, A_MASK, 0, 0, rd, er, cyc);
        check("post_rst_mask", rd, 32'd0);
        apb(0, 0, A_MODE, 0, 0, rd, er, cyc);
        check("post_rst_mode", rd, 32'd0);
        apb(0, 0, A_STAT, 0, 0, rd, er, cyc);
        check("post_rst_status", rd, 32'd0);
        apb(0, 0, A_EVT, 0, 0, rd, er, cyc);
        check("post_rst_evt", rd, 32'd0);
        apb(1, 0, A_SCR, 0, 0, rd, er, cyc);
        check("post_rst_scratch", rd, 32'hAF);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
